// File: rtl/sync_74148_encoder_pkg.sv
// Shared types, sizes and the priority helper for the clocked 74148-style encoder.
package pkg_74148;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  // Highest set bit wins; an empty vector maps to 0.
  function automatic logic [CODE_W-1:0] prio_idx(input logic [N_REQ-1:0] req);
    prio_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req[k]) prio_idx = k[CODE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sync_74148_encoder_if.sv
// Request/grant bundle between the encoder and its producer/consumer side.
interface sync_74148_encoder_if;
  import pkg_74148::*;

  logic [N_REQ-1:0]  in_n_i;
  logic              ei_n_i;
  logic              ack_i;
  logic [CODE_W-1:0] code_n_o;
  logic              gs_n_o;
  logic              eo_n_o;
  logic [N_REQ-1:0]  pending_o;
  logic              overrun_o;

  modport master (
    output in_n_i, ei_n_i, ack_i,
    input  code_n_o, gs_n_o, eo_n_o, pending_o, overrun_o
  );

  modport slave (
    input  in_n_i, ei_n_i, ack_i,
    output code_n_o, gs_n_o, eo_n_o, pending_o, overrun_o
  );
endinterface

// File: rtl/sync_74148_encoder_sync.sv
// Multi-flop synchronizer for one active-low line; flops reset to the inactive level (1).
module sync_bit_n #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_n_i,
  output logic q_n_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_n_i};
    end
  end

  assign q_n_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_74148_encoder.sv
// Clocked 8-to-3 priority encoder with 74148-style active-low pins, pending-request
// latching and a valid/ack handshake; eo_n_o allows two instances to cascade.
module sync_74148_encoder
  import pkg_74148::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sync_74148_encoder_if.slave bus
);

  logic [N_REQ-1:0]  in_n_sync;
  logic              ei_n_sync;
  logic              en;
  logic [N_REQ-1:0]  pending_q;
  logic              overrun_q;
  state_t            state_q;
  logic [CODE_W-1:0] idx_q;
  logic [CODE_W-1:0] code_n_q;
  logic              gs_n_q;
  logic              eo_n_q;

  for (genvar k = 0; k < N_REQ; k++) begin : g_sync
    sync_bit_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_n_i (bus.in_n_i[k]),
      .q_n_o (in_n_sync[k])
    );
  end

  sync_bit_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ei (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_n_i (bus.ei_n_i),
    .q_n_o (ei_n_sync)
  );

  assign en = ~ei_n_sync;

  if (EDGE_MODE != 0) begin : g_edge
    logic [N_REQ-1:0] prev_q;
    logic [N_REQ-1:0] fall;
    logic [N_REQ-1:0] clr;

    assign fall = prev_q & ~in_n_sync;

    // An ack is only honoured while enabled; an abort cycle ignores it.
    always_comb begin
      clr = '0;
      if (state_q == VALID && en && bus.ack_i) clr[idx_q] = 1'b1;
    end

    // A new edge beats a same-cycle clear, so the request is never lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        prev_q    <= '1;
        pending_q <= '0;
        overrun_q <= 1'b0;
      end else begin
        prev_q    <= in_n_sync;
        pending_q <= (pending_q & ~clr) | fall;
        overrun_q <= overrun_q | (|(fall & pending_q));
      end
    end
  end else begin : g_level
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pending_q <= '0;
        overrun_q <= 1'b0;
      end else begin
        pending_q <= ~in_n_sync;
        overrun_q <= 1'b0;
      end
    end
  end

  // Grant leaves VALID on ack, on loss of enable, or when a level request is withdrawn.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      code_n_q <= '1;
      gs_n_q   <= 1'b1;
      eo_n_q   <= 1'b1;
    end else begin
      eo_n_q <= ~(en & (pending_q == '0) & (state_q == IDLE));
      case (state_q)
        IDLE: begin
          if (en && pending_q != '0) begin
            state_q  <= VALID;
            idx_q    <= prio_idx(pending_q);
            code_n_q <= ~prio_idx(pending_q);
            gs_n_q   <= 1'b0;
          end
        end
        VALID: begin
          if (!en || bus.ack_i || !pending_q[idx_q]) begin
            state_q  <= IDLE;
            code_n_q <= '1;
            gs_n_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.code_n_o  = code_n_q;
  assign bus.gs_n_o    = gs_n_q;
  assign bus.eo_n_o    = eo_n_q;
  assign bus.pending_o = pending_q;
  assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_sync_74148_encoder.sv
// Directed bench: edge-mode instance for handshake/priority/overrun/abort/reset,
// plus a level-mode instance for held requests.
module tb_sync_74148_encoder;
  import pkg_74148::*;

  logic clk_i;
  logic rst_i;
  int   checkCount;
  int   passCount;

  sync_74148_encoder_if bus0 ();
  sync_74148_encoder_if bus1 ();

  sync_74148_encoder #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut_edge (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus0.slave)
  );

  sync_74148_encoder #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_level (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus1.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] in_n, input logic ei_n, input logic ack);
    bus0.in_n_i = in_n;
    bus0.ei_n_i = ei_n;
    bus0.ack_i  = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic ackPulse();
    bus0.ack_i = 1'b1;
    tick(1);
    bus0.ack_i = 1'b0;
  endtask

  initial begin
    checkCount  = 0;
    passCount   = 0;
    rst_i       = 1'b1;
    applyStimulus(8'hFF, 1'b1, 1'b0);
    bus1.in_n_i = 8'hFF;
    bus1.ei_n_i = 1'b0;
    bus1.ack_i  = 1'b0;
    tick(2);
    rst_i = 1'b0;

    // reset and idle
    checkOutput("rst_code", {5'd0, bus0.code_n_o}, 8'h07);
    checkOutput("rst_gs", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("rst_eo", {7'd0, bus0.eo_n_o}, 8'h01);
    checkOutput("rst_pending", bus0.pending_o, 8'h00);
    checkOutput("rst_overrun", {7'd0, bus0.overrun_o}, 8'h00);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    tick(2);
    checkOutput("eo_not_yet", {7'd0, bus0.eo_n_o}, 8'h01);
    tick(1);
    checkOutput("eo_enabled", {7'd0, bus0.eo_n_o}, 8'h00);
    checkOutput("idle_pending", bus0.pending_o, 8'h00);

    // single request on bit 2
    applyStimulus(8'hFB, 1'b0, 1'b0);
    tick(3);
    checkOutput("single_gs_early", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("single_pending", bus0.pending_o, 8'h04);
    tick(1);
    checkOutput("single_gs", {7'd0, bus0.gs_n_o}, 8'h00);
    checkOutput("single_code", {5'd0, bus0.code_n_o}, 8'h05);
    checkOutput("single_eo", {7'd0, bus0.eo_n_o}, 8'h01);
    ackPulse();
    checkOutput("single_ack_gs", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("single_ack_code", {5'd0, bus0.code_n_o}, 8'h07);
    checkOutput("single_ack_pend", bus0.pending_o, 8'h00);
    tick(1);
    checkOutput("single_ack_eo", {7'd0, bus0.eo_n_o}, 8'h00);
    bus0.in_n_i = 8'hFF;
    tick(3);

    // bits 7, 5, 1 together: served 7, 5, 1
    bus0.in_n_i = 8'h5D;
    tick(3);
    checkOutput("multi_pending", bus0.pending_o, 8'hA2);
    tick(1);
    checkOutput("multi_code7", {5'd0, bus0.code_n_o}, 8'h00);
    ackPulse();
    checkOutput("multi_gap1", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("multi_pend_after7", bus0.pending_o, 8'h22);
    tick(1);
    checkOutput("multi_gs5", {7'd0, bus0.gs_n_o}, 8'h00);
    checkOutput("multi_code5", {5'd0, bus0.code_n_o}, 8'h02);
    ackPulse();
    checkOutput("multi_gap2", {7'd0, bus0.gs_n_o}, 8'h01);
    tick(1);
    checkOutput("multi_code1", {5'd0, bus0.code_n_o}, 8'h06);

    // bit 7 arrives while code 1 is held
    bus0.in_n_i = 8'hFF;
    tick(3);
    bus0.in_n_i = 8'h7F;
    tick(3);
    checkOutput("hold_pending", bus0.pending_o, 8'h82);
    checkOutput("hold_code1", {5'd0, bus0.code_n_o}, 8'h06);
    checkOutput("hold_gs", {7'd0, bus0.gs_n_o}, 8'h00);
    ackPulse();
    checkOutput("hold_gap", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("hold_pend_after1", bus0.pending_o, 8'h80);
    tick(1);
    checkOutput("hold_code7", {5'd0, bus0.code_n_o}, 8'h00);
    ackPulse();
    checkOutput("hold_drained", bus0.pending_o, 8'h00);
    bus0.in_n_i = 8'hFF;
    tick(3);

    // overrun: bit 3 pulsed twice before ack
    bus0.in_n_i = 8'hF7;
    tick(4);
    checkOutput("ovr_code3", {5'd0, bus0.code_n_o}, 8'h04);
    checkOutput("ovr_before", {7'd0, bus0.overrun_o}, 8'h00);
    bus0.in_n_i = 8'hFF;
    tick(3);
    bus0.in_n_i = 8'hF7;
    tick(3);
    checkOutput("ovr_set", {7'd0, bus0.overrun_o}, 8'h01);
    checkOutput("ovr_code_held", {5'd0, bus0.code_n_o}, 8'h04);
    ackPulse();
    checkOutput("ovr_pend_clr", bus0.pending_o, 8'h00);
    checkOutput("ovr_sticky", {7'd0, bus0.overrun_o}, 8'h01);

    // fall on bit 3 in the same cycle as its ack
    bus0.in_n_i = 8'hFF;
    tick(3);
    bus0.in_n_i = 8'hF7;
    tick(4);
    checkOutput("sw_grant", {5'd0, bus0.code_n_o}, 8'h04);
    bus0.in_n_i = 8'hFF;
    tick(3);
    bus0.in_n_i = 8'hF7;
    tick(2);
    ackPulse();
    checkOutput("sw_gs", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("sw_pending", bus0.pending_o, 8'h08);
    tick(1);
    checkOutput("sw_regrant_gs", {7'd0, bus0.gs_n_o}, 8'h00);
    checkOutput("sw_regrant_code", {5'd0, bus0.code_n_o}, 8'h04);
    ackPulse();
    bus0.in_n_i = 8'hFF;
    tick(3);
    checkOutput("sw_drained", bus0.pending_o, 8'h00);

    // enable abort with ack ignored, then re-grant
    bus0.in_n_i = 8'hBF;
    tick(4);
    checkOutput("abort_code6", {5'd0, bus0.code_n_o}, 8'h01);
    bus0.ei_n_i = 1'b1;
    tick(2);
    ackPulse();
    checkOutput("abort_gs", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("abort_code", {5'd0, bus0.code_n_o}, 8'h07);
    checkOutput("abort_pending", bus0.pending_o, 8'h40);
    checkOutput("abort_eo", {7'd0, bus0.eo_n_o}, 8'h01);
    bus0.ei_n_i = 1'b0;
    tick(3);
    checkOutput("abort_regrant_gs", {7'd0, bus0.gs_n_o}, 8'h00);
    checkOutput("abort_regrant_code", {5'd0, bus0.code_n_o}, 8'h01);
    ackPulse();
    bus0.in_n_i = 8'hFF;
    tick(3);

    // async reset mid-VALID with input held low
    bus0.in_n_i = 8'hDF;
    tick(4);
    checkOutput("ar_code5", {5'd0, bus0.code_n_o}, 8'h02);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("ar_gs", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("ar_code", {5'd0, bus0.code_n_o}, 8'h07);
    checkOutput("ar_pending", bus0.pending_o, 8'h00);
    checkOutput("ar_overrun", {7'd0, bus0.overrun_o}, 8'h00);
    checkOutput("ar_eo", {7'd0, bus0.eo_n_o}, 8'h01);
    #2;
    rst_i = 1'b0;
    tick(4);
    checkOutput("ar_post_code", {5'd0, bus0.code_n_o}, 8'h02);
    checkOutput("ar_post_ovr", {7'd0, bus0.overrun_o}, 8'h00);
    ackPulse();
    checkOutput("ar_post_pend", bus0.pending_o, 8'h00);
    tick(2);
    checkOutput("ar_no_spurious", {7'd0, bus0.gs_n_o}, 8'h01);
    checkOutput("ar_no_ovr", {7'd0, bus0.overrun_o}, 8'h00);

    // level mode: held bit 4
    bus1.in_n_i = 8'hEF;
    tick(4);
    checkOutput("lvl_gs", {7'd0, bus1.gs_n_o}, 8'h00);
    checkOutput("lvl_code4", {5'd0, bus1.code_n_o}, 8'h03);
    checkOutput("lvl_pending", bus1.pending_o, 8'h10);
    tick(5);
    checkOutput("lvl_hold_gs", {7'd0, bus1.gs_n_o}, 8'h00);
    checkOutput("lvl_hold_code", {5'd0, bus1.code_n_o}, 8'h03);
    checkOutput("lvl_overrun", {7'd0, bus1.overrun_o}, 8'h00);
    bus1.in_n_i = 8'hFF;
    tick(2);
    checkOutput("lvl_rel_early", {7'd0, bus1.gs_n_o}, 8'h00);
    tick(2);
    checkOutput("lvl_rel_gs", {7'd0, bus1.gs_n_o}, 8'h01);
    checkOutput("lvl_rel_code", {5'd0, bus1.code_n_o}, 8'h07);
    checkOutput("lvl_rel_pend", bus1.pending_o, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
